// File: rtl/qspi_target_if.sv
// qspi_target_if: pad-level QSPI bus between a master and the target.
// Master drives SCK/CSN/DQ in; target returns DQ out and enables.
interface qspi_target_if;
  logic       sck_i;
  logic       csn_i;
  logic [3:0] dq_i;
  logic [3:0] dq_o;
  logic [3:0] dq_en;

  modport master (
    output sck_i,
    output csn_i,
    output dq_i,
    input  dq_o,
    input  dq_en
  );

  modport slave (
    input  sck_i,
    input  csn_i,
    input  dq_i,
    output dq_o,
    output dq_en
  );
endinterface

// File: rtl/qspi_target.sv
// qspi_target: oversampled QSPI responder with a 16-byte register bank.
// SPI mode 0, single or quad lanes, write events and local read port.
module qspi_target #(
  parameter int SYNC_STAGES = 2,
  parameter int QUAD_DUMMY  = 2
) (
  input  logic         clk,
  input  logic         rst,
  qspi_target_if.slave spi,
  output logic         quad_mode,
  output logic         wr_evt_vld,
  output logic [3:0]   wr_evt_addr,
  output logic [7:0]   wr_evt_dat,
  input  logic [3:0]   lcl_raddr,
  output logic [7:0]   lcl_rdat
);
  localparam logic [7:0] CMD_WR   = 8'h02;
  localparam logic [7:0] CMD_RD   = 8'h0B;
  localparam logic [7:0] CMD_QON  = 8'h35;
  localparam logic [7:0] CMD_QOFF = 8'hF5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_WDATA,
    S_RDATA,
    S_IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] sync_q [SYNC_STAGES];
  logic       sck_s, csn_s, sck_d, csn_d;
  logic [3:0] dq_s;
  logic       rise, fall;
  logic [2:0] bcnt;
  logic [3:0] step, sum;
  logic       done;
  logic [7:0] sh_in, byte_nx, sh_out;
  logic [3:0] addr, addr_inc;
  logic [7:0] dcnt;
  logic       dlast;
  logic       is_wr, pend_vld, pend_val;
  logic [3:0] dq_o_q, dq_en_q;
  logic [7:0] bank [16];

  assign {sck_s, csn_s, dq_s} = sync_q[SYNC_STAGES-1];
  assign rise     = sck_s & ~sck_d;
  assign fall     = ~sck_s & sck_d;
  assign step     = quad_mode ? 4'd4 : 4'd1;
  assign sum      = {1'b0, bcnt} + step;
  assign done     = sum[3];
  assign byte_nx  = quad_mode ? {sh_in[3:0], dq_s}
                              : {sh_in[6:0], dq_s[0]};
  assign addr_inc = addr + 4'd1;
  assign dlast    = (dcnt == 8'(QUAD_DUMMY - 1));
  assign spi.dq_o  = dq_o_q;
  assign spi.dq_en = dq_en_q;
  assign lcl_rdat  = bank[lcl_raddr];

  // Pad synchronizers; CSN resets low so a frame already in
  // progress at reset release never looks like a fresh select.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sck_d <= 1'b0;
      csn_d <= 1'b0;
    end else begin
      sync_q[0] <= {spi.sck_i, spi.csn_i, spi.dq_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sck_d <= sck_s;
      csn_d <= csn_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Frame sequencing; deselect overrides every state.
  always_comb begin
    state_d = state_q;
    if (csn_s) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (csn_d) state_d = S_CMD;
        S_CMD: begin
          if (rise && done) begin
            if (byte_nx == CMD_WR || byte_nx == CMD_RD)
              state_d = S_ADDR;
            else
              state_d = S_IGNORE;
          end
        end
        S_ADDR: begin
          if (rise && done) begin
            if (is_wr)
              state_d = S_WDATA;
            else if (quad_mode && QUAD_DUMMY > 0)
              state_d = S_DUMMY;
            else
              state_d = S_RDATA;
          end
        end
        S_DUMMY: if (rise && dlast) state_d = S_RDATA;
        default: state_d = state_q;
      endcase
    end
  end

  // Shift registers, bank writes, read drive and mode changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt        <= '0;
      sh_in       <= '0;
      sh_out      <= '0;
      addr        <= '0;
      dcnt        <= '0;
      is_wr       <= 1'b0;
      pend_vld    <= 1'b0;
      pend_val    <= 1'b0;
      quad_mode   <= 1'b0;
      dq_o_q      <= '0;
      dq_en_q     <= '0;
      wr_evt_vld  <= 1'b0;
      wr_evt_addr <= '0;
      wr_evt_dat  <= '0;
      for (int i = 0; i < 16; i++) bank[i] <= '0;
    end else begin
      wr_evt_vld <= 1'b0;
      if (csn_s) begin
        bcnt     <= '0;
        dcnt     <= '0;
        dq_o_q   <= '0;
        dq_en_q  <= '0;
        pend_vld <= 1'b0;
        if (pend_vld) quad_mode <= pend_val;
      end else begin
        unique case (state_q)
          S_CMD: begin
            if (rise) begin
              sh_in <= byte_nx;
              bcnt  <= sum[2:0];
              if (done) begin
                is_wr <= (byte_nx == CMD_WR);
                unique case (1'b1)
                  byte_nx == CMD_QON: begin
                    pend_vld <= 1'b1;
                    pend_val <= 1'b1;
                  end
                  byte_nx == CMD_QOFF: begin
                    pend_vld <= 1'b1;
                    pend_val <= 1'b0;
                  end
                  default: ;
                endcase
              end
            end
          end
          S_ADDR: begin
            if (rise) begin
              sh_in <= byte_nx;
              bcnt  <= sum[2:0];
              if (done) begin
                addr   <= byte_nx[3:0];
                sh_out <= bank[byte_nx[3:0]];
              end
            end
          end
          S_DUMMY: begin
            if (rise) begin
              dcnt <= dcnt + 8'd1;
              if (dlast) sh_out <= bank[addr];
            end
          end
          S_WDATA: begin
            if (rise) begin
              sh_in <= byte_nx;
              bcnt  <= sum[2:0];
              if (done) begin
                bank[addr]  <= byte_nx;
                wr_evt_vld  <= 1'b1;
                wr_evt_addr <= addr;
                wr_evt_dat  <= byte_nx;
                addr        <= addr_inc;
              end
            end
          end
          S_RDATA: begin
            if (fall) begin
              bcnt <= sum[2:0];
              if (quad_mode) begin
                dq_o_q  <= sh_out[7:4];
                dq_en_q <= 4'hF;
              end else begin
                dq_o_q  <= {2'b00, sh_out[7], 1'b0};
                dq_en_q <= 4'b0010;
              end
              if (done) begin
                addr   <= addr_inc;
                sh_out <= bank[addr_inc];
              end else if (quad_mode) begin
                sh_out <= {sh_out[3:0], 4'h0};
              end else begin
                sh_out <= {sh_out[6:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_qspi_target.sv
// tb_qspi_target: directed QSPI master with a write-event and
// read-data scoreboard against a bench-side register model.
module tb_qspi_target;
  logic       clk = 1'b0;
  logic       rst;
  logic       quad_mode;
  logic       wr_evt_vld;
  logic [3:0] wr_evt_addr;
  logic [7:0] wr_evt_dat;
  logic [3:0] lcl_raddr;
  logic [7:0] lcl_rdat;

  int errors = 0;
  int checks = 0;

  logic [11:0] evq [$];
  logic [7:0]  rdq [$];
  logic [7:0]  mdl [16];

  qspi_target_if bus ();

  qspi_target #(
    .SYNC_STAGES(2),
    .QUAD_DUMMY (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (bus.slave),
    .quad_mode  (quad_mode),
    .wr_evt_vld (wr_evt_vld),
    .wr_evt_addr(wr_evt_addr),
    .wr_evt_dat (wr_evt_dat),
    .lcl_raddr  (lcl_raddr),
    .lcl_rdat   (lcl_rdat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Each write event must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && wr_evt_vld) begin
      logic [12:0] want;
      want = '0;
      if (evq.size() > 0) want = {1'b1, evq.pop_front()};
      check("wr_evt", {1'b1, wr_evt_addr, wr_evt_dat}, want);
    end
  end

  task automatic wait_half();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [3:0] d,
                     output logic [3:0] q,
                     output logic [3:0] en);
    bus.dq_i = d;
    wait_half();
    q  = bus.dq_o;
    en = bus.dq_en;
    bus.sck_i = 1'b1;
    wait_half();
    bus.sck_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit quad);
    logic [3:0] q, en;
    if (quad) begin
      cyc(b[7:4], q, en);
      cyc(b[3:0], q, en);
    end else begin
      for (int i = 7; i >= 0; i--) cyc({3'b000, b[i]}, q, en);
    end
  endtask

  task automatic csn_low();
    bus.csn_i = 1'b0;
    wait_half();
  endtask

  task automatic csn_high();
    wait_half();
    bus.csn_i = 1'b1;
    wait_half();
    wait_half();
  endtask

  task automatic write_frame(input logic [3:0] a0,
                             input logic [7:0] d0,
                             input logic [7:0] d1,
                             input int n,
                             input bit quad);
    logic [3:0] a;
    logic [7:0] d;
    a = a0;
    csn_low();
    send_byte(8'h02, quad);
    send_byte({4'h0, a0}, quad);
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : d1;
      evq.push_back({a, d});
      mdl[a] = d;
      a = a + 4'd1;
      send_byte(d, quad);
    end
    csn_high();
    check("evq_drained", evq.size(), 0);
  endtask

  task automatic read_frame(input logic [3:0] a0,
                            input int n,
                            input bit quad);
    logic [3:0] a, q, en;
    logic [7:0] rx;
    a = a0;
    for (int i = 0; i < n; i++) begin
      rdq.push_back(mdl[a]);
      a = a + 4'd1;
    end
    csn_low();
    send_byte(8'h0B, quad);
    send_byte({4'h0, a0}, quad);
    if (quad) begin
      for (int i = 0; i < 2; i++) begin
        cyc(4'h0, q, en);
        check("dummy_en", en, 0);
      end
    end
    for (int i = 0; i < n; i++) begin
      rx = '0;
      en = '0;
      if (quad) begin
        for (int k = 0; k < 2; k++) begin
          cyc(4'h0, q, en);
          rx = {rx[3:0], q};
        end
      end else begin
        for (int k = 0; k < 8; k++) begin
          cyc(4'h0, q, en);
          rx = {rx[6:0], q[1]};
        end
      end
      check("rd_en", en, quad ? 4'hF : 4'h2);
      check("rd_byte", rx, rdq.pop_front());
    end
    csn_high();
    check("rd_en_off", bus.dq_en, 0);
  endtask

  task automatic mode_frame(input logic [7:0] c,
                            input bit quad,
                            input bit want);
    csn_low();
    send_byte(c, quad);
    wait_half();
    check("mode_pending", quad_mode, quad);
    csn_high();
    check("mode_applied", quad_mode, want);
  endtask

  initial begin
    logic [3:0] q, en;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    rst       = 1'b1;
    bus.sck_i = 1'b0;
    bus.csn_i = 1'b1;
    bus.dq_i  = 4'h0;
    lcl_raddr = 4'h0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_dq_en", bus.dq_en, 0);
    check("rst_dq_o", bus.dq_o, 0);
    check("rst_quad", quad_mode, 0);
    check("rst_evt", wr_evt_vld, 0);
    check("rst_evt_addr", wr_evt_addr, 0);
    check("rst_evt_dat", wr_evt_dat, 0);
    for (int i = 0; i < 16; i++) begin
      lcl_raddr = 4'(i);
      #1 check("rst_bank", lcl_rdat, 0);
    end
    repeat (6) @(posedge clk);

    write_frame(4'h5, 8'hA5, 8'h00, 1, 1'b0);
    lcl_raddr = 4'h5;
    #1 check("lcl_after_wr", lcl_rdat, mdl[5]);

    read_frame(4'h5, 2, 1'b0);

    mode_frame(8'h35, 1'b0, 1'b1);
    write_frame(4'hF, 8'h11, 8'h22, 2, 1'b1);
    lcl_raddr = 4'h0;
    #1 check("lcl_wrap", lcl_rdat, mdl[0]);
    read_frame(4'hF, 2, 1'b1);

    mode_frame(8'hF5, 1'b1, 1'b0);

    csn_low();
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'(i & 1), q, en);
    csn_high();
    lcl_raddr = 4'h3;
    #1 check("abort_bank", lcl_rdat, mdl[3]);
    write_frame(4'h3, 8'h3C, 8'h00, 1, 1'b0);
    #1 check("after_abort", lcl_rdat, mdl[3]);

    csn_low();
    send_byte(8'h9F, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc(4'($urandom_range(0, 15)), q, en);
      check("unk_en", en, 0);
    end
    csn_high();
    check("unk_quad", quad_mode, 0);
    check("unk_evq", evq.size(), 0);

    read_frame(4'h2, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
